// File: rtl/vga_ram_arbiter.sv
// vga_ram_arbiter: shares one single-port VGA RAM between the mono text
// VGA engine (absolute priority, slot announced one cycle ahead) and the
// CPU (latched request, serviced in free cycles, one-cycle ack pulse).
module vga_ram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_vga_addr,
    input  logic                  i_vga_cs,
    input  logic                  i_vga_access,
    output logic [DATA_WIDTH-1:0] o_vga_dat,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_dat,
    input  logic                  i_cpu_we,
    input  logic                  i_cpu_cs,
    output logic [DATA_WIDTH-1:0] o_cpu_dat,
    output logic                  o_cpu_ack,
    output logic                  o_cpu_busy,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_dat,
    output logic                  o_ram_we,
    output logic                  o_ram_cs,
    input  logic [DATA_WIDTH-1:0] i_ram_dat,
    output logic                  o_vga_error
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PENDING = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]            state;
    logic                  r_vga_slot;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_dat;
    logic                  lat_we;
    logic                  vga_own;
    logic                  cpu_go;

    // The VGA engine owns the cycle it reserved last cycle, and also any cycle
    // it drives cs in (even unreserved -- that case is flagged as an error).
    assign vga_own    = r_vga_slot || i_vga_cs;
    assign cpu_go     = (state == S_PENDING) && !vga_own;
    assign o_cpu_busy = (state != S_IDLE);
    assign o_vga_dat  = i_ram_dat;

    // Slot reservation: the access announcement takes effect one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_vga_slot <= 1'b0;
        else         r_vga_slot <= i_vga_access;
    end

    // CPU request FSM: capture in IDLE, wait for a free cycle, ack for one cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (i_cpu_cs) state <= S_PENDING;
                S_PENDING: if (cpu_go)   state <= S_DONE;
                S_DONE:                  state <= S_IDLE;
                default:                 state <= S_IDLE;
            endcase
        end
    end

    // Request latch; loaded only when a new request is accepted in IDLE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lat_addr <= '0;
            lat_dat  <= '0;
            lat_we   <= 1'b0;
        end else if (state == S_IDLE && i_cpu_cs) begin
            lat_addr <= i_cpu_addr;
            lat_dat  <= i_cpu_dat;
            lat_we   <= i_cpu_we;
        end
    end

    // CPU completion: ack pulses in the cycle after the RAM access; read data
    // is held until the next read completes (writes leave it alone).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_cpu_ack <= 1'b0;
            o_cpu_dat <= '0;
        end else begin
            o_cpu_ack <= cpu_go;
            if (cpu_go && !lat_we) o_cpu_dat <= i_ram_dat;
        end
    end

    // Sticky protocol error: VGA select without a reserved slot.
    always_ff @(posedge i_clk) begin
        if (i_reset)                        o_vga_error <= 1'b0;
        else if (i_vga_cs && !r_vga_slot)   o_vga_error <= 1'b1;
    end

    // RAM port mux: VGA first, then the pending CPU access, otherwise idle.
    always_comb begin
        o_ram_addr = '0;
        o_ram_dat  = '0;
        o_ram_we   = 1'b0;
        o_ram_cs   = 1'b0;
        if (vga_own) begin
            o_ram_addr = i_vga_addr;
            o_ram_cs   = i_vga_cs;
        end else if (cpu_go) begin
            o_ram_addr = lat_addr;
            o_ram_dat  = lat_dat;
            o_ram_we   = lat_we;
            o_ram_cs   = 1'b1;
        end
    end

endmodule
